memory_readout_packer: RTL and testbench
========================================

Name: memory_readout_packer

Overview:
- Downstream readout stage of BlockMemoryStorage.
- After storage is filled, it walks every row/column address, issues single-bit read requests (readMemory), and collects storedValue bits returned with readReady.
- Packs each row's NUMCOLS bits into one word and emits it with its row index over a valid/ready handshake to the next consumer (output FIFO/serial link).

Parameters:
- ROWINDEXBITS, 4, row index width; rows = 2**ROWINDEXBITS.
- COLINDEXBITS, 3, column index width; NUMCOLS = 2**COLINDEXBITS = packed word width.
- SKIPEMPTY, 0, when 1 rows whose packed word is all-zero are not emitted.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse: begin full readout; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- readMemory  out  1  one-cycle read request to storage.
- readAddress  out  COLINDEXBITS+ROWINDEXBITS  {row, col}, col in low bits; valid when readMemory=1.
- readReady  in  1  storage response strobe; storedValue valid this cycle.
- storedValue  in  1  bit read from storage.
- outValid  out  1  packed word available.
- outReady  in  1  consumer accepts word when outValid&outReady.
- outRow  out  ROWINDEXBITS  row index of outWord.
- outWord  out  NUMCOLS  bit c = stored bit at column c.
- wordsEmitted  out  ROWINDEXBITS+1  count of accepted words this readout.
- done  out  1  one-cycle pulse at end of readout.
- protocolError  out  1  sticky: readReady outside WAIT.

Behaviour:
- Reset (async, any state): state=IDLE; row=0, col=0, word=0; all outputs 0 (busy, readMemory, readAddress, outValid, outRow, outWord, wordsEmitted, done, protocolError). Reset mid-readout abandons the request; a late readReady after reset in IDLE sets protocolError.
- States: IDLE, REQUEST, WAIT, EMIT, DONE.
- IDLE: start=1 -> REQUEST next cycle; row=col=0, word=0, wordsEmitted=0, protocolError unchanged. start in any other state is ignored.
- REQUEST: readMemory=1 for exactly this cycle, readAddress={row,col}; -> WAIT unconditionally.
- WAIT: readMemory=0; hold until readReady=1 (latency unbounded, no timeout). On readReady: word[col]<=storedValue.
  - col<NUMCOLS-1 -> col+1, REQUEST.
  - Last col: -> EMIT, unless SKIPEMPTY=1 and the completed word (including this bit) is zero, in which case go to the next row directly (REQUEST with col=0, word=0, or DONE if last row).
- Minimum 2 cycles per bit; one outstanding request max.
- EMIT: outValid=1, outRow=row, outWord=word, all stable until handshake. On outValid&outReady: wordsEmitted+1; row=last -> DONE, else row+1, col=0, word=0, REQUEST. outValid deasserts the cycle after handshake.
- DONE: done=1 one cycle, busy=1; -> IDLE. wordsEmitted holds until next start.
- protocolError: set when readReady=1 in IDLE, REQUEST, EMIT or DONE; cleared only by reset. The stray response is otherwise ignored and state unaffected.
- Counters: col wraps only via row advance; row never wraps, since the last row goes to DONE. wordsEmitted max = 2**ROWINDEXBITS, hence the +1 bit.
- Total minimum readout with outReady tied high: rows*(2*NUMCOLS+1)+2 cycles.

Decomposition:
- Shared header (MyParameters.vh): ROWINDEXBITS, COLINDEXBITS, derived NUMCOLS and address width, state encodings (3-bit localparams).
- One natural sub-module: readout_bit_packer (col counter + word register + zero detect). The FSM stays in the top.

Test Plan (bench: ROWINDEXBITS=2, COLINDEXBITS=2, storage model with programmable latency):
- Reset then idle, no start -> all outputs 0, busy=0 for 20 cycles; reset asserted mid-WAIT -> outputs 0 within the same cycle, no outValid afterwards.
- Memory rows = 4'b0001, 4'b1010, 4'b0000, 4'b1111, latency 1, outReady=1 -> 4 words in order (row 0..3), outWord = 1, A, 0, F; wordsEmitted=4; done pulse at cycle 38 after start; 16 readMemory pulses with addresses 0..15.
- Same memory, SKIPEMPTY=1 -> words for rows 0, 1, 3 only; wordsEmitted=3.
- outReady held low 10 cycles on row 1 -> outValid/outRow=1/outWord=A stable throughout, no new readMemory until handshake.
- Random storage latency 1-7 cycles -> identical word sequence; never two readMemory pulses without an intervening readReady.
- readReady injected in IDLE and during EMIT -> protocolError=1 and sticky; words unaffected; start during busy ignored (wordsEmitted still 4).

Source files
------------

// File: rtl/memory_readout_packer_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the memory readout packer.
package memory_readout_packer_pkg;

  localparam int unsigned DefRowIndexBits = 4;
  localparam int unsigned DefColIndexBits = 3;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRequest = 3'd1,
    StWait    = 3'd2,
    StEmit    = 3'd3,
    StDone    = 3'd4
  } state_e;

  function automatic int unsigned num_cols(input int unsigned col_bits);
    return 1 << col_bits;
  endfunction

endpackage

// File: rtl/memory_readout_packer_if.sv
// Storage read port plus packed-word output stream of the readout packer.
interface memory_readout_packer_if
  import memory_readout_packer_pkg::*;
#(
  parameter int unsigned RowIndexBits = DefRowIndexBits,
  parameter int unsigned ColIndexBits = DefColIndexBits
);
  localparam int unsigned NumCols = num_cols(ColIndexBits);

  logic                                 read_memory;
  logic [RowIndexBits+ColIndexBits-1:0] read_address;
  logic                                 read_ready;
  logic                                 stored_value;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [RowIndexBits-1:0]              out_row;
  logic [NumCols-1:0]                   out_word;

  modport master (
    output read_memory, read_address, out_valid, out_row, out_word,
    input  read_ready, stored_value, out_ready
  );

  modport slave (
    input  read_memory, read_address, out_valid, out_row, out_word,
    output read_ready, stored_value, out_ready
  );
endinterface

// File: rtl/memory_readout_packer_bit_packer.sv
// Column counter and word register that assemble one row's bits into a packed word.
module memory_readout_packer_bit_packer
  import memory_readout_packer_pkg::*;
#(
  parameter int unsigned ColIndexBits = DefColIndexBits
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                capture_i,
  input  logic                                bit_i,
  output logic [ColIndexBits-1:0]             col_o,
  output logic                                last_col_o,
  output logic [num_cols(ColIndexBits)-1:0]   word_o,
  output logic                                word_zero_o
);
  localparam int unsigned NumCols = num_cols(ColIndexBits);
  localparam logic [ColIndexBits-1:0] ColOne = 1;

  logic [ColIndexBits-1:0] col_q, col_d;
  logic [NumCols-1:0]      word_q, word_d, word_cap;

  always_comb begin
    word_cap        = word_q;
    word_cap[col_q] = bit_i;
    col_d           = col_q;
    word_d          = word_q;
    if (clear_i) begin
      col_d  = '0;
      word_d = '0;
    end else if (capture_i) begin
      word_d = word_cap;
      // Column holds at the last bit; only a row advance clears it.
      if (!last_col_o) col_d = col_q + ColOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q  <= '0;
      word_q <= '0;
    end else begin
      col_q  <= col_d;
      word_q <= word_d;
    end
  end

  assign col_o       = col_q;
  assign last_col_o  = (col_q == {ColIndexBits{1'b1}});
  assign word_o      = word_q;
  // Zero test includes the bit arriving this cycle.
  assign word_zero_o = (word_cap == '0);

endmodule

// File: rtl/memory_readout_packer.sv
// Walks every storage address with single-bit reads and emits one packed word per row.
module memory_readout_packer
  import memory_readout_packer_pkg::*;
#(
  parameter int unsigned RowIndexBits = DefRowIndexBits,
  parameter int unsigned ColIndexBits = DefColIndexBits,
  parameter bit          SkipEmpty    = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic [RowIndexBits:0]   words_emitted_o,
  output logic                    done_o,
  output logic                    protocol_error_o,
  memory_readout_packer_if.master bus
);
  localparam int unsigned NumCols = num_cols(ColIndexBits);
  localparam logic [RowIndexBits-1:0] RowOne   = 1;
  localparam logic [RowIndexBits:0]   WordsOne = 1;

  state_e                  state_q, state_d;
  logic [RowIndexBits-1:0] row_q, row_d;
  logic [RowIndexBits:0]   words_q, words_d;
  logic                    perr_q, perr_d;

  logic                    clear, capture, last_col, word_zero, last_row;
  logic [ColIndexBits-1:0] col;
  logic [NumCols-1:0]      word;

  memory_readout_packer_bit_packer #(
    .ColIndexBits (ColIndexBits)
  ) u_bit_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear),
    .capture_i   (capture),
    .bit_i       (bus.stored_value),
    .col_o       (col),
    .last_col_o  (last_col),
    .word_o      (word),
    .word_zero_o (word_zero)
  );

  assign last_row = (row_q == {RowIndexBits{1'b1}});

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    words_d = words_q;
    clear   = 1'b0;
    capture = 1'b0;
    // A response is only legal while a request is outstanding.
    perr_d  = perr_q | (bus.read_ready && (state_q != StWait));
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRequest;
          row_d   = '0;
          words_d = '0;
          clear   = 1'b1;
        end
      end
      StRequest: state_d = StWait;
      StWait: begin
        if (bus.read_ready) begin
          capture = 1'b1;
          if (!last_col) begin
            state_d = StRequest;
          end else if (SkipEmpty && word_zero) begin
            if (last_row) begin
              state_d = StDone;
            end else begin
              state_d = StRequest;
              row_d   = row_q + RowOne;
              clear   = 1'b1;
            end
          end else begin
            state_d = StEmit;
          end
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          words_d = words_q + WordsOne;
          if (last_row) begin
            state_d = StDone;
          end else begin
            state_d = StRequest;
            row_d   = row_q + RowOne;
            clear   = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      row_q   <= '0;
      words_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      words_q <= words_d;
      perr_q  <= perr_d;
    end
  end

  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StDone);
  assign words_emitted_o  = words_q;
  assign protocol_error_o = perr_q;

  assign bus.read_memory  = (state_q == StRequest);
  assign bus.read_address = (state_q == StRequest) ? {row_q, col} : '0;
  assign bus.out_valid    = (state_q == StEmit);
  assign bus.out_row      = (state_q == StEmit) ? row_q : '0;
  assign bus.out_word     = (state_q == StEmit) ? word : '0;

endmodule

// File: tb/tb_memory_readout_packer.sv
// Directed bench: 4x4 storage model with programmable latency, two packers (plain and skip-empty).
module tb_memory_readout_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a, start_b;
  logic busy_a, busy_b, done_a, done_b, perr_a, perr_b;
  logic [2:0] words_a, words_b;

  logic rdy_a, rdy_b, inj_a;
  logic mdl_ready_a = 1'b0, mdl_val_a = 1'b0;
  logic mdl_ready_b = 1'b0, mdl_val_b = 1'b0;
  int   lat_fix = 1;
  bit   lat_rand = 1'b0;

  logic [3:0] rows_mem [0:3] = '{4'b0001, 4'b1010, 4'b0000, 4'b1111};

  int n_chk = 0;
  int n_fail = 0;

  // Results of the last readout on instance A.
  logic [1:0] got_row  [16];
  logic [3:0] got_word [16];
  int n_got, n_reads, done_at, stall_n;
  bit addr_err, overlap;

  always #5 clk = ~clk;

  memory_readout_packer_if #(.RowIndexBits(2), .ColIndexBits(2)) bus_a ();
  memory_readout_packer_if #(.RowIndexBits(2), .ColIndexBits(2)) bus_b ();

  memory_readout_packer #(.RowIndexBits(2), .ColIndexBits(2), .SkipEmpty(1'b0)) dut_a (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start_a),
    .busy_o           (busy_a),
    .words_emitted_o  (words_a),
    .done_o           (done_a),
    .protocol_error_o (perr_a),
    .bus              (bus_a)
  );

  memory_readout_packer #(.RowIndexBits(2), .ColIndexBits(2), .SkipEmpty(1'b1)) dut_b (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start_b),
    .busy_o           (busy_b),
    .words_emitted_o  (words_b),
    .done_o           (done_b),
    .protocol_error_o (perr_b),
    .bus              (bus_b)
  );

  assign bus_a.read_ready   = mdl_ready_a | inj_a;
  assign bus_a.stored_value = mdl_val_a;
  assign bus_a.out_ready    = rdy_a;
  assign bus_b.read_ready   = mdl_ready_b;
  assign bus_b.stored_value = mdl_val_b;
  assign bus_b.out_ready    = rdy_b;

  function automatic logic mem_bit(input logic [3:0] a);
    logic [3:0] r;
    r = rows_mem[a[3:2]];
    return r[a[1:0]];
  endfunction

  // Storage model A: response arrives `lat` cycles after the request cycle.
  logic       pend_a = 1'b0;
  int         cnt_a = 0;
  logic [3:0] addr_a = '0;
  always @(posedge clk) begin : model_a
    int l;
    mdl_ready_a <= 1'b0;
    if (pend_a) begin
      if (cnt_a == 1) begin
        mdl_ready_a <= 1'b1;
        mdl_val_a   <= mem_bit(addr_a);
        pend_a      <= 1'b0;
      end else begin
        cnt_a <= cnt_a - 1;
      end
    end
    if (bus_a.read_memory) begin
      l = lat_rand ? int'($urandom_range(7, 1)) : lat_fix;
      if (l == 1) begin
        mdl_ready_a <= 1'b1;
        mdl_val_a   <= mem_bit(bus_a.read_address);
      end else begin
        pend_a <= 1'b1;
        cnt_a  <= l - 1;
        addr_a <= bus_a.read_address;
      end
    end
  end

  always @(posedge clk) begin
    mdl_ready_b <= bus_b.read_memory;
    mdl_val_b   <= mem_bit(bus_b.read_address);
  end

  function automatic logic [17:0] outs_a();
    return {busy_a, bus_a.read_memory, bus_a.read_address, bus_a.out_valid, bus_a.out_row,
            bus_a.out_word, words_a, done_a, perr_a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full readout on A; optional row-1 backpressure, EMIT-time stray response, busy start.
  task automatic run_a(input bit stall_row1, input bit poke_emit, input bit poke_start);
    bit outstanding, poked;
    n_got = 0; n_reads = 0; done_at = -1; stall_n = 0;
    addr_err = 1'b0; overlap = 1'b0; outstanding = 1'b0; poked = 1'b0;
    for (int i = 0; i < 16; i++) begin
      got_row[i]  = 'x;
      got_word[i] = 'x;
    end
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int cyc = 1; cyc <= 2000 && done_at < 0; cyc++) begin
      start_a = poke_start && (cyc == 5);
      if (stall_row1 && bus_a.out_valid && bus_a.out_row == 2'd1 && stall_n < 10) begin
        rdy_a = 1'b0;
        stall_n++;
        check("stall_valid", 32'(bus_a.out_valid), 32'd1);
        check("stall_row", 32'(bus_a.out_row), 32'd1);
        check("stall_word", 32'(bus_a.out_word), 32'hA);
        check("stall_no_req", 32'(bus_a.read_memory), 32'd0);
      end else begin
        rdy_a = 1'b1;
      end
      inj_a = poke_emit && bus_a.out_valid && !poked;
      if (inj_a) poked = 1'b1;
      if (mdl_ready_a) outstanding = 1'b0;
      if (bus_a.read_memory) begin
        if (outstanding) overlap = 1'b1;
        if (32'(bus_a.read_address) != n_reads) addr_err = 1'b1;
        n_reads++;
        outstanding = 1'b1;
      end
      if (bus_a.out_valid && bus_a.out_ready && n_got < 16) begin
        got_row[n_got]  = bus_a.out_row;
        got_word[n_got] = bus_a.out_word;
        n_got++;
      end
      if (done_a) done_at = cyc;
      @(negedge clk);
    end
    inj_a = 1'b0;
    start_a = 1'b0;
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count"}, 32'(n_got), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_row"}, 32'(got_row[i]), 32'(i));
      check({tag, "_word"}, 32'(got_word[i]), 32'(rows_mem[i]));
    end
    check({tag, "_emitted"}, 32'(words_a), 32'd4);
    check({tag, "_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_reads"}, 32'(n_reads), 32'd16);
  endtask

  initial begin
    bit saw_valid, b_done;
    int nb;
    logic [5:0] got_b [4];
    start_a = 1'b0; start_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1; inj_a = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs_a()), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outs", 32'(outs_a()), 32'd0);
    end

    // Latency 1, no backpressure: done lands in the 38th cycle counting the start cycle.
    run_a(1'b0, 1'b0, 1'b0);
    check("l1_done_cycle", 32'(done_at), 32'd37);
    check("l1_addr_seq", 32'(addr_err), 32'd0);
    check("l1_perr", 32'(perr_a), 32'd0);
    check_words("l1");

    // Skip-empty instance: row 2 is all zero and must not appear.
    nb = 0; b_done = 1'b0;
    for (int i = 0; i < 4; i++) got_b[i] = 'x;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int c = 0; c < 400 && !b_done; c++) begin
      if (bus_b.out_valid && bus_b.out_ready && nb < 4) begin
        got_b[nb] = {bus_b.out_row, bus_b.out_word};
        nb++;
      end
      if (done_b) b_done = 1'b1;
      @(negedge clk);
    end
    check("skip_done", 32'(b_done), 32'd1);
    check("skip_count", 32'(nb), 32'd3);
    check("skip_w0", 32'(got_b[0]), 32'h01);
    check("skip_w1", 32'(got_b[1]), 32'h1A);
    check("skip_w2", 32'(got_b[2]), 32'h3F);
    check("skip_emitted", 32'(words_b), 32'd3);

    run_a(1'b1, 1'b0, 1'b0);
    check("stall_cycles", 32'(stall_n), 32'd10);
    check_words("stall");

    lat_rand = 1'b1;
    run_a(1'b0, 1'b0, 1'b0);
    lat_rand = 1'b0;
    check("rand_addr_seq", 32'(addr_err), 32'd0);
    check_words("rand");

    // Stray response in IDLE, then during EMIT, with a start pulse while busy.
    inj_a = 1'b1;
    @(negedge clk); inj_a = 1'b0;
    check("perr_idle", 32'(perr_a), 32'd1);
    check("perr_idle_busy", 32'(busy_a), 32'd0);
    run_a(1'b0, 1'b1, 1'b1);
    check("perr_sticky", 32'(perr_a), 32'd1);
    check_words("perr");

    // Reset during WAIT; the late response then lands in IDLE.
    lat_fix = 3;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 20 && !bus_a.read_memory; i++) @(negedge clk);
    check("rst_req_seen", 32'(bus_a.read_memory), 32'd1);
    @(negedge clk);
    check("rst_in_wait", 32'({busy_a, bus_a.read_memory}), 32'h2);
    rst = 1'b1;
    #1 check("rst_mid_outs", 32'(outs_a()), 32'd0);
    @(negedge clk); rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_a.out_valid) saw_valid = 1'b1;
    end
    check("rst_no_valid", 32'(saw_valid), 32'd0);
    check("rst_late_perr", 32'(perr_a), 32'd1);
    check("rst_idle_busy", 32'(busy_a), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
